// File: rtl/regdump.sv
// regdump: walks a contiguous, inclusive range of register-file addresses and
// streams each (index, value) pair out over a valid/ready interface, then pulses done.
module regdump #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StFin} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] end_q, end_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;

  // State and beat registers; reset clears everything without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      end_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      end_q      <= end_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  // Next-state: capture the range on start, fetch one register, hold it until accepted.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_d   = first;
          end_d   = last;
          // An inverted range completes immediately with no beats.
          state_d = (first <= last) ? StRead : StFin;
        end
      end
      StRead: begin
        out_addr_d = cur_q;
        out_data_d = rd_data;
        state_d    = StSend;
      end
      StSend: begin
        if (out_ready) begin
          // Equality stop keeps cur from ever wrapping at the top of the address space.
          if (cur_q == end_q) begin
            state_d = StFin;
          end else begin
            cur_d   = cur_q + AW'(1);
            state_d = StRead;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are pure functions of the registered state.
  always_comb begin
    busy      = (state_q != StIdle);
    out_valid = (state_q == StSend);
    done      = (state_q == StFin);
    rd_addr   = (state_q == StIdle) ? '0 : cur_q;
    out_addr  = out_addr_q;
    out_data  = out_data_q;
  end

endmodule

// File: tb/tb_regdump.sv
// Bench for regdump: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a transaction-level model.
module tb_regdump;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] first = '0;
  logic [AW-1:0] last = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [NREG];

  regdump #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .first    (first),
    .last     (last),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
  );

  assign rd_data = mem[rd_addr];

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pending beat addresses, plus when the next beat must appear.
  int unsigned q[$];
  bit m_busy = 1'b0;
  bit m_valid = 1'b0;
  bit m_done = 1'b0;
  int m_wait = 0;

  // Compare process: one check pass per cycle, away from the rising edge.
  always @(negedge clk) begin
    bit nb, nd;
    if (reset) begin
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_out_addr", out_addr, 0);
      check("rst_out_data", out_data, 0);
      q.delete();
      m_busy = 1'b0;
      m_valid = 1'b0;
      m_done = 1'b0;
      m_wait = 0;
    end else begin
      check("out_valid", out_valid, m_valid);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      if (!m_busy) check("idle_rd_addr", rd_addr, 0);
      else if (q.size() > 0) check("rd_addr", rd_addr, q[0]);
      if (m_valid && q.size() > 0) begin
        check("out_addr", out_addr, q[0]);
        check("out_data", out_data, mem[q[0]]);
      end
      nb = m_busy;
      nd = 1'b0;
      if (m_done) nb = 1'b0;
      if (!m_busy && start) begin
        nb = 1'b1;
        if (first <= last) begin
          for (int a = int'(first); a <= int'(last); a++) q.push_back(a);
          m_wait = 2;
        end else begin
          nd = 1'b1;
        end
      end
      if (m_valid && out_ready) begin
        void'(q.pop_front());
        m_valid = 1'b0;
        if (q.size() == 0) nd = 1'b1;
        else m_wait = 2;
      end
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_valid = 1'b1;
      end
      m_busy = nb;
      m_done = nd;
    end
  end

  int beats, dones;
  logic [AW-1:0] la;
  logic [DW-1:0] ld;

  // Sample handshakes just before the edge, then advance to 1 time unit after it.
  task automatic cycle();
    #3;
    if (out_valid && out_ready) begin
      beats++;
      la = out_addr;
      ld = out_data;
    end
    if (done) dones++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input int f, input int l);
    beats = 0;
    dones = 0;
    first = AW'(f);
    last = AW'(l);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // mode 0: always ready; mode 1: stall each beat for 3 cycles before accepting.
  task automatic finish_dump(input int mode);
    int k, sc;
    sc = 0;
    for (k = 0; k < 2000; k++) begin
      if (dones > 0 && !busy) break;
      if (mode == 0) begin
        out_ready = 1'b1;
      end else if (out_valid) begin
        sc++;
        out_ready = (sc > 3);
      end else begin
        sc = 0;
        out_ready = 1'b0;
      end
      cycle();
    end
    check("dump_timeout", k < 2000, 1);
    out_ready = 1'b1;
  endtask

  initial begin
    int lat, k;
    for (int i = 0; i < NREG; i++) mem[i] = 32'h1000 + i;
    mem[0] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_out_data", out_data, 0);

    // Full range, always ready.
    out_ready = 1'b1;
    start_dump(0, 31);
    finish_dump(0);
    check("full_beats", beats, 32);
    check("full_last_addr", la, 31);
    check("full_last_data", ld, 32'h101F);
    check("full_dones", dones, 1);

    // Single register: latency of two cycles.
    start_dump(5, 5);
    lat = 1;
    while (!out_valid && lat < 10) begin
      cycle();
      lat++;
    end
    check("single_latency", lat, 2);
    check("single_addr", out_addr, 5);
    check("single_data", out_data, 32'h1005);
    finish_dump(0);
    check("single_beats", beats, 1);
    check("single_dones", dones, 1);

    // Inverted range: immediate done, no beats.
    start_dump(9, 3);
    check("inv_done", done, 1);
    check("inv_busy", busy, 1);
    cycle();
    check("inv_done_after", done, 0);
    check("inv_busy_after", busy, 0);
    finish_dump(0);
    check("inv_beats", beats, 0);

    // Backpressure: every beat stalled 3 cycles.
    start_dump(2, 4);
    finish_dump(1);
    check("stall_beats", beats, 3);
    check("stall_last_addr", la, 4);
    check("stall_last_data", ld, 32'h1004);

    // Start while busy is ignored.
    start_dump(10, 12);
    cycle();
    cycle();
    first = '0;
    last = 5'd31;
    start = 1'b1;
    cycle();
    start = 1'b0;
    finish_dump(0);
    check("ign_beats", beats, 3);
    check("ign_last_addr", la, 12);
    check("ign_dones", dones, 1);

    // Asynchronous reset during beat 3, then a fresh dump.
    start_dump(0, 31);
    k = 0;
    while (!(out_valid && out_addr == 3) && k < 100) begin
      cycle();
      k++;
    end
    check("beat3_seen", k < 100, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", out_valid, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_dump(0, 1);
    finish_dump(0);
    check("post_rst_beats", beats, 2);
    check("post_rst_last", la, 1);
    check("post_rst_data", ld, 32'h1001);
    check("post_rst_dones", dones, 1);

    // Random phase.
    for (int i = 0; i < NREG; i++) mem[i] = $urandom;
    for (int c = 0; c < 4000; c++) begin
      out_ready = ($urandom_range(3) != 0);
      start = ($urandom_range(7) == 0);
      first = AW'($urandom_range(31));
      last = AW'($urandom_range(31));
      if ($urandom_range(299) == 0) begin
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
      end else begin
        cycle();
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (100) cycle();
    check("drain_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regdump.md
REGDUMP -- requirements
Module: regdump

Interface
REQ-001: Parameter AW, default 5, register-address width; the block supports 2**AW registers.
REQ-002: Parameter DW, default 32, register data width.
REQ-003: clk  input  1  single clock; all state updates on posedge clk.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: start  input  1  request to begin a dump; sampled only in IDLE.
REQ-006: first  input  AW  first register of the range, captured with start.
REQ-007: last  input  AW  last register of the range (inclusive), captured with start.
REQ-008: rd_addr  output  AW  read address driven to a register-file read port.
REQ-009: rd_data  input  DW  combinational read data returned for rd_addr in the same cycle.
REQ-010: out_valid  output  1  dump beat valid.
REQ-011: out_ready  input  1  downstream accepts the beat.
REQ-012: out_addr  output  AW  register index of the current beat.
REQ-013: out_data  output  DW  register value of the current beat.
REQ-014: busy  output  1  high from the cycle after start is accepted until the cycle after the final handshake.
REQ-015: done  output  1  single-cycle pulse marking completion of a dump.

Function
REQ-016: FSM states SHALL be IDLE, READ, SEND, FIN; reset state is IDLE.
REQ-017: IDLE: busy=0, out_valid=0, rd_addr=0; start=1 latches cur<=first and end<=last.
REQ-018: IDLE with start and first<=last -> READ; with start and first>last -> FIN with no beats emitted.
REQ-019: READ: rd_addr=cur; the block registers out_addr<=cur and out_data<=rd_data, sets out_valid, and goes to SEND after exactly one cycle.
REQ-020: SEND: out_valid=1; out_addr and out_data held stable until out_valid&&out_ready.
REQ-021: SEND handshake with cur==end -> FIN; otherwise cur<=cur+1 -> READ.
REQ-022: out_valid deasserts in the cycle after the handshake; a beat is never dropped or duplicated.
REQ-023: FIN: done=1 for exactly one cycle, then IDLE; busy=1 in READ, SEND, FIN.
REQ-024: Latency: start to first out_valid = 2 cycles; peak throughput = 1 beat per 2 cycles.
REQ-025: Termination uses the equality cur==end, so last=2**AW-1 ends without wrap-around and cur is never incremented past end.
REQ-026: start while busy=1 is ignored; first and last are not re-sampled.
REQ-027: Register 0 is not special-cased; out_data is whatever rd_data returns, including write bypass.
REQ-028: rd_addr in SEND and FIN holds cur (no glitch on the read port).

Reset
REQ-029: reset=1 immediately forces IDLE, out_valid=0, busy=0, done=0, rd_addr=0, out_addr=0, out_data=0, cur=0, end=0, independent of clk.
REQ-030: Reset mid-dump abandons the dump with no done pulse; the first start after reset release is serviced normally.

Verification
REQ-031: Register file preloaded with mem[i]=0x1000+i (mem[0] reads 0), first=0, last=31, out_ready=1 -> 32 beats with out_addr 0..31 and out_data 0,0x1001..0x101F; done pulses one cycle after the beat with out_addr 31; busy drops with done.
REQ-032: first=5, last=5 -> exactly one beat (5, 0x1005); first out_valid 2 cycles after start; then done.
REQ-033: first=9, last=3 -> zero beats; done high 1 cycle after start; busy high only in that cycle.
REQ-034: first=2, last=4, out_ready held low 3 cycles on each beat -> out_addr/out_data stable while stalled; exactly 3 beats (2,3,4), in order.
REQ-035: start pulsed again with first=0 mid-dump (first=10, last=12) -> ignored; beats 10..12 only; a single done pulse.
REQ-036: reset asserted between clock edges during beat 3 of a 0..31 dump -> out_valid and busy drop without a clock edge; no done pulse; a new dump of 0..1 after release yields beats 0,1.
